// File: rtl/chunked_add_sub_pkg.sv
// Shared encodings for the chunked adder/subtractor and the NZCV flag decoder.
// Holds the op codes, FSM states, flag bit positions and op-decode helpers.
package chunked_add_sub_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBC = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Bit positions inside the 4-bit NZCV word built by the flag decoder.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic op_inverts_b(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SBC);
   endfunction

   function automatic logic op_carry_in(input logic [1:0] op, input logic c_flag);
      logic ci;
      case (op)
         OP_ADD:  ci = 1'b0;
         OP_SUB:  ci = 1'b1;
         default: ci = c_flag;
      endcase
      return ci;
   endfunction

endpackage

// File: rtl/chunked_add_sub_add_chunk.sv
// Combinational CHUNK-bit ripple adder exposing the carry out of every bit,
// so the parent can report per-bit carries for the flag decoder.
module add_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic [CHUNK-1:0] carry
);

   logic c_run;

   always_comb begin
      sum   = '0;
      carry = '0;
      c_run = ci;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a_chunk[i] ^ b_chunk[i] ^ c_run;
         carry[i] = (a_chunk[i] & b_chunk[i]) | (c_run & (a_chunk[i] ^ b_chunk[i]));
         c_run    = carry[i];
      end
   end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle W-bit add/subtract, CHUNK bits per cycle LSB first, producing the
// sum and per-bit carry vectors consumed by the NZCV flag decoder.
//
// state  | meaning
// S_IDLE | waiting for a request; in_ready high
// S_BUSY | one chunk per cycle added with the running carry
// S_DONE | result held with out_valid high until out_ready
module chunked_add_sub
   import chunked_add_sub_pkg::*;
#(
   parameter int W     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_flag,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sout,
   output logic [W-1:0] cout
);

   localparam int N     = W / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if ((W < 2) || (CHUNK < 1) || ((W % CHUNK) != 0)) begin : g_bad_params
      $error("chunked_add_sub: CHUNK must divide W and W must be at least 2");
   end

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sout_q, sout_d;
   logic [W-1:0]     cout_q, cout_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [31:0]      base;
   logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk, carry_chunk;

   // A single adder instance is shared across cycles; the chunk index steers it.
   assign base    = 32'(idx_q) * 32'(CHUNK);
   assign a_chunk = a_q[base +: CHUNK];
   assign b_chunk = b_q[base +: CHUNK];

   add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
      .a_chunk (a_chunk),
      .b_chunk (b_chunk),
      .ci      (carry_q),
      .sum     (sum_chunk),
      .carry   (carry_chunk)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sout_d  = sout_q;
      cout_d  = cout_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = op_inverts_b(op) ? ~b : b;
               carry_d = op_carry_in(op, c_flag);
               sout_d  = '0;
               cout_d  = '0;
               idx_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            sout_d[base +: CHUNK] = sum_chunk;
            cout_d[base +: CHUNK] = carry_chunk;
            carry_d               = carry_chunk[CHUNK-1];
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sout_q  <= '0;
         cout_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sout_q  <= sout_d;
         cout_q  <= cout_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sout      = sout_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: three parameterisations driven by directed and
// random operations, checked against an arithmetic model of sum and carries.
module tb_chunked_add_sub;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        c_in = 1'b0;
   logic [2:0]  in_valid_v = '0;
   logic [2:0]  out_ready_v = '0;

   logic        in_ready0, out_valid0;
   logic [31:0] sout0, cout0;
   logic        in_ready1, out_valid1;
   logic [7:0]  sout1, cout1;
   logic        in_ready2, out_valid2;
   logic [15:0] sout2, cout2;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   chunked_add_sub #(.W(32), .CHUNK(8)) dut0 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
      .op(op), .a(a_in), .b(b_in), .c_flag(c_in),
      .out_valid(out_valid0), .out_ready(out_ready_v[0]), .sout(sout0), .cout(cout0)
   );

   chunked_add_sub #(.W(8), .CHUNK(8)) dut1 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
      .op(op), .a(a_in[7:0]), .b(b_in[7:0]), .c_flag(c_in),
      .out_valid(out_valid1), .out_ready(out_ready_v[1]), .sout(sout1), .cout(cout1)
   );

   chunked_add_sub #(.W(16), .CHUNK(4)) dut2 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
      .op(op), .a(a_in[15:0]), .b(b_in[15:0]), .c_flag(c_in),
      .out_valid(out_valid2), .out_ready(out_ready_v[2]), .sout(sout2), .cout(cout2)
   );

   function automatic int width_of(input int i);
      return (i == 0) ? 32 : (i == 1) ? 8 : 16;
   endfunction

   function automatic int chunks_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 4;
   endfunction

   function automatic logic [31:0] get_sout(input int i);
      return (i == 0) ? sout0 : (i == 1) ? {24'd0, sout1} : {16'd0, sout2};
   endfunction

   function automatic logic [31:0] get_cout(input int i);
      return (i == 0) ? cout0 : (i == 1) ? {24'd0, cout1} : {16'd0, cout2};
   endfunction

   function automatic logic get_valid(input int i);
      return (i == 0) ? out_valid0 : (i == 1) ? out_valid1 : out_valid2;
   endfunction

   function automatic logic get_ready(input int i);
      return (i == 0) ? in_ready0 : (i == 1) ? in_ready1 : in_ready2;
   endfunction

   // Reference: result = A + B' + ci over w bits; carry out of bit i is the
   // overflow of the sum restricted to the low i+1 bits.
   function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                         input logic [31:0] av, input logic [31:0] bv,
                                         input logic cv);
      longint unsigned mask, am, bp, ci, m, part;
      logic [31:0] s, c;
      mask = (64'd1 << w) - 64'd1;
      am   = {32'd0, av} & mask;
      case (o)
         2'b00: begin bp = {32'd0, bv} & mask;  ci = 0;                  end
         2'b01: begin bp = {32'd0, ~bv} & mask; ci = 1;                  end
         2'b10: begin bp = {32'd0, bv} & mask;  ci = {63'd0, cv};        end
         default: begin bp = {32'd0, ~bv} & mask; ci = {63'd0, cv};      end
      endcase
      s = 32'((am + bp + ci) & mask);
      c = '0;
      for (int i = 0; i < w; i++) begin
         m    = (64'd1 << (i + 1)) - 64'd1;
         part = ((am & m) + (bp & m) + ci) >> (i + 1);
         c[i] = part[0];
      end
      return {c, s};
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input int inst, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic cv, input int stall);
      logic [63:0] exp;
      int lat;
      exp = model(width_of(inst), o, av, bv, cv);
      @(negedge clk);
      op = o; a_in = av; b_in = bv; c_in = cv;
      in_valid_v[inst] = 1'b1;
      check("in_ready_idle", 96'(get_ready(inst)), 96'd1);
      @(negedge clk);
      in_valid_v[inst] = 1'b0;
      op = 2'($urandom); a_in = $urandom; b_in = $urandom; c_in = 1'($urandom);
      lat = 0;
      while (!get_valid(inst) && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 96'(lat), 96'(chunks_of(inst)));
      repeat (stall) @(negedge clk);
      check("sout", 96'(get_sout(inst)), 96'(exp[31:0]));
      check("cout", 96'(get_cout(inst)), 96'(exp[63:32]));
      check("done_flags", 96'({get_valid(inst), get_ready(inst)}), 96'(2'b10));
      out_ready_v[inst] = 1'b1;
      @(negedge clk);
      out_ready_v[inst] = 1'b0;
      check("back_idle", 96'({get_valid(inst), get_ready(inst)}), 96'(2'b01));
   endtask

   initial begin
      int lat;
      logic [31:0] ra, rb;

      #3;
      for (int i = 0; i < 3; i++) begin
         check("reset_flags", 96'({get_valid(i), get_ready(i)}), 96'(2'b01));
         check("reset_data", 96'({get_sout(i), get_cout(i)}), 96'd0);
      end
      @(negedge clk);
      resetn = 1'b1;

      // Directed cases on the 32-bit instance.
      do_op(0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
      do_op(0, 2'b01, 32'd5, 32'd5, 1'b0, 1);
      do_op(0, 2'b11, 32'd0, 32'd0, 1'b0, 0);
      do_op(0, 2'b10, 32'hFFFF_FFFF, 32'd0, 1'b1, 2);
      check("model_add_ovf", 96'(model(32, 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0)),
            96'({32'h7FFF_FFFF, 32'h8000_0000}));

      // Backpressure with ignored requests during BUSY and DONE.
      @(negedge clk);
      op = 2'b00; a_in = 32'd3; b_in = 32'd4; in_valid_v[0] = 1'b1;
      @(negedge clk);
      a_in = 32'h1234_5678; b_in = 32'h1234_5678;
      check("bp_busy_ready", 96'(in_ready0), 96'd0);
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      lat = 0;
      while (!out_valid0 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check("bp_latency", 96'(lat), 96'd3);
      for (int k = 0; k < 10; k++) begin
         in_valid_v[0] = (k == 5);
         check("bp_hold", 96'({out_valid0, in_ready0, sout0, cout0}),
               96'({1'b1, 1'b0, 32'd7, 32'd0}));
         @(negedge clk);
      end
      in_valid_v[0] = 1'b0;
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      out_ready_v[0] = 1'b0;
      check("bp_release", 96'({out_valid0, in_ready0}), 96'(2'b01));
      repeat (8) @(negedge clk);
      check("bp_no_ghost", 96'({out_valid0, in_ready0}), 96'(2'b01));

      // Asynchronous reset during the second BUSY cycle.
      op = 2'b00; a_in = 32'h1111_1111; b_in = 32'h2222_2222; in_valid_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      @(negedge clk);
      check("mid_partial", 96'(sout0[7:0]), 96'(8'h33));
      #1 resetn = 1'b0;
      #1;
      check("mid_rst_flags", 96'({out_valid0, in_ready0}), 96'(2'b01));
      check("mid_rst_data", 96'({sout0, cout0}), 96'd0);
      @(negedge clk);
      resetn = 1'b1;
      do_op(0, 2'b00, 32'd1, 32'd1, 1'b0, 0);

      // Random sweep over all three parameterisations.
      for (int inst = 0; inst < 3; inst++) begin
         for (int k = 0; k < 25; k++) begin
            ra = (k % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (k % 5 == 0) ? 32'd0 : $urandom;
            do_op(inst, 2'($urandom), ra, rb, 1'($urandom), $urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
